// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: synchronous write, asynchronous read.
// Contents are deliberately not reset so the array can map onto plain registers or distributed RAM.
module sync_fifo_mem #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             wclken,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = 2 ** ASIZE;

    logic [DSIZE-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wclken) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty flags,
// sticky overflow/underflow errors and a selectable first-word-fall-through read port.
module sync_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int FWFT  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic [DSIZE-1:0] rdata,
    input  logic             rinc,
    output logic             rempty,
    output logic [ASIZE:0]   count,
    input  logic [ASIZE:0]   afull_thresh,
    input  logic [ASIZE:0]   aempty_thresh,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int             DEPTH      = 2 ** ASIZE;
    localparam logic [ASIZE:0] FULL_COUNT = (ASIZE + 1)'(DEPTH);
    localparam logic [ASIZE:0] COUNT_ONE  = (ASIZE + 1)'(1);
    localparam logic [ASIZE-1:0] PTR_ONE  = (ASIZE)'(1);

    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;
    logic [ASIZE:0]   r_count;
    logic             r_wfull;
    logic             r_rempty;
    logic             r_almostFull;
    logic             r_almostEmpty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_we;
    logic             w_re;
    logic [ASIZE:0]   w_countNext;
    logic [DSIZE-1:0] w_memRdata;

    // Accepts look only at the registered flags, so a same-cycle pop never frees room for a push.
    assign w_we = winc & ~r_wfull;
    assign w_re = rinc & ~r_rempty;

    always_comb begin
        w_countNext = r_count;
        if (w_we && !w_re) begin
            w_countNext = r_count + COUNT_ONE;
        end else if (!w_we && w_re) begin
            w_countNext = r_count - COUNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_wfull       <= 1'b0;
            r_rempty      <= 1'b1;
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
        end else begin
            if (w_we) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_re) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            r_count       <= w_countNext;
            r_wfull       <= (w_countNext == FULL_COUNT);
            r_rempty      <= (w_countNext == '0);
            r_almostFull  <= (w_countNext >= afull_thresh);
            r_almostEmpty <= (w_countNext <= aempty_thresh);
        end
    end

    // Error flags are sticky; a new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (winc & r_wfull)  | (r_overflow  & ~clr_err);
            r_underflow <= (rinc & r_rempty) | (r_underflow & ~clr_err);
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk    (clk),
        .wclken (w_we),
        .waddr  (r_wptr),
        .wdata  (wdata),
        .raddr  (r_rptr),
        .rdata  (w_memRdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = w_memRdata;
        end else begin : g_std
            logic [DSIZE-1:0] r_rdata;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (w_re) begin
                    r_rdata <= w_memRdata;
                end
            end

            assign rdata = r_rdata;
        end
    endgenerate

    assign count        = r_count;
    assign wfull        = r_wfull;
    assign rempty       = r_rempty;
    assign almost_full  = r_almostFull;
    assign almost_empty = r_almostEmpty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-mode instance and an FWFT instance, both DEPTH = 4.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] afullThresh = 3'd3;
    logic [2:0] aemptyThresh = 3'd1;
    logic       clrErr = 1'b0;

    logic [7:0] wdata = '0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic       wfull, rempty, almostFull, almostEmpty, overflow, underflow;
    logic [7:0] rdata;
    logic [2:0] count;

    logic [7:0] fWdata = '0;
    logic       fWinc = 1'b0;
    logic       fRinc = 1'b0;
    logic       fWfull, fRempty, fAfull, fAempty, fOver, fUnder;
    logic [7:0] fRdata;
    logic [2:0] fCount;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(8), .ASIZE(2), .FWFT(0)) dut (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull),
        .rdata(rdata), .rinc(rinc), .rempty(rempty), .count(count),
        .afull_thresh(afullThresh), .aempty_thresh(aemptyThresh),
        .almost_full(almostFull), .almost_empty(almostEmpty),
        .overflow(overflow), .underflow(underflow), .clr_err(clrErr)
    );

    sync_fifo #(.DSIZE(8), .ASIZE(2), .FWFT(1)) dutF (
        .clk(clk), .rst_n(rst_n), .wdata(fWdata), .winc(fWinc), .wfull(fWfull),
        .rdata(fRdata), .rinc(fRinc), .rempty(fRempty), .count(fCount),
        .afull_thresh(afullThresh), .aempty_thresh(aemptyThresh),
        .almost_full(fAfull), .almost_empty(fAempty),
        .overflow(fOver), .underflow(fUnder), .clr_err(clrErr)
    );

    // Inputs change 1 time unit after a rising edge and outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseClear();
        clrErr = 1'b1;
        tick();
        clrErr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL resetCount actual=%0d required=0", count); end
        checks++; if (rempty !== 1'b1) begin failures++; $display("[TB] FAIL resetRempty actual=%b required=1", rempty); end
        checks++; if (wfull !== 1'b0) begin failures++; $display("[TB] FAIL resetWfull actual=%b required=0", wfull); end
        checks++; if (almostEmpty !== 1'b1) begin failures++; $display("[TB] FAIL resetAlmostEmpty actual=%b required=1", almostEmpty); end
        checks++; if (almostFull !== 1'b0) begin failures++; $display("[TB] FAIL resetAlmostFull actual=%b required=0", almostFull); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("[TB] FAIL resetErrors actual=%b required=00", {overflow, underflow}); end
        checks++; if (rdata !== 8'h00) begin failures++; $display("[TB] FAIL resetRdata actual=%h required=00", rdata); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        logic [7:0] expData;
        for (int i = 0; i < 4; i++) begin
            wdata = 8'((i + 1) * 17);
            winc = 1'b1;
            tick();
            checks++; if (count !== 3'(i + 1)) begin failures++; $display("[TB] FAIL fillCount%0d actual=%0d required=%0d", i, count, i + 1); end
            checks++; if (almostFull !== (i >= 2)) begin failures++; $display("[TB] FAIL fillAlmostFull%0d actual=%b required=%b", i, almostFull, (i >= 2)); end
            checks++; if (wfull !== (i == 3)) begin failures++; $display("[TB] FAIL fillWfull%0d actual=%b required=%b", i, wfull, (i == 3)); end
        end
        winc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rinc = 1'b1;
            tick();
            expData = 8'((i + 1) * 17);
            checks++; if (rdata !== expData) begin failures++; $display("[TB] FAIL drainData%0d actual=%h required=%h", i, rdata, expData); end
            checks++; if (count !== 3'(3 - i)) begin failures++; $display("[TB] FAIL drainCount%0d actual=%0d required=%0d", i, count, 3 - i); end
            checks++; if (almostEmpty !== (i >= 2)) begin failures++; $display("[TB] FAIL drainAlmostEmpty%0d actual=%b required=%b", i, almostEmpty, (i >= 2)); end
        end
        rinc = 1'b0;
        checks++; if (rempty !== 1'b1) begin failures++; $display("[TB] FAIL drainRempty actual=%b required=1", rempty); end
        tick();
        checks++; if (rdata !== 8'h44) begin failures++; $display("[TB] FAIL rdataHold actual=%h required=44", rdata); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            wdata = 8'(8'hA0 + i);
            winc = 1'b1;
            tick();
        end
        wdata = 8'h55;
        tick();
        winc = 1'b0;
        checks++; if (count !== 3'd4) begin failures++; $display("[TB] FAIL ovfCount actual=%0d required=4", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovfSet actual=%b required=1", overflow); end
        tick();
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovfSticky actual=%b required=1", overflow); end
        pulseClear();
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovfClear actual=%b required=0", overflow); end
        winc = 1'b1;
        clrErr = 1'b1;
        tick();
        winc = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovfSetWins actual=%b required=1", overflow); end
        tick();
        clrErr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovfClear2 actual=%b required=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            rinc = 1'b1;
            tick();
            checks++; if (rdata !== 8'(8'hA0 + i)) begin failures++; $display("[TB] FAIL ovfDrain%0d actual=%h required=%h", i, rdata, 8'(8'hA0 + i)); end
        end
        tick();
        rinc = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("[TB] FAIL udfSet actual=%b required=1", underflow); end
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL udfCount actual=%0d required=0", count); end
        checks++; if (rdata !== 8'hA3) begin failures++; $display("[TB] FAIL udfRdata actual=%h required=a3", rdata); end
        pulseClear();
        checks++; if (underflow !== 1'b0) begin failures++; $display("[TB] FAIL udfClear actual=%b required=0", underflow); end
    endtask

    task automatic test_simultaneous();
        wdata = 8'h66;
        winc = 1'b1;
        rinc = 1'b1;
        tick();
        winc = 1'b0;
        rinc = 1'b0;
        checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL simEmptyCount actual=%0d required=1", count); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("[TB] FAIL simEmptyUnderflow actual=%b required=1", underflow); end
        checks++; if (rempty !== 1'b0) begin failures++; $display("[TB] FAIL simEmptyRempty actual=%b required=0", rempty); end
        pulseClear();
        for (int i = 0; i < 3; i++) begin
            wdata = 8'(8'h77 + 8'h11 * i);
            winc = 1'b1;
            tick();
        end
        checks++; if (wfull !== 1'b1) begin failures++; $display("[TB] FAIL simFullWfull actual=%b required=1", wfull); end
        wdata = 8'hEE;
        rinc = 1'b1;
        tick();
        winc = 1'b0;
        rinc = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("[TB] FAIL simFullCount actual=%0d required=3", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL simFullOverflow actual=%b required=1", overflow); end
        checks++; if (rdata !== 8'h66) begin failures++; $display("[TB] FAIL simFullHead actual=%h required=66", rdata); end
        checks++; if (wfull !== 1'b0) begin failures++; $display("[TB] FAIL simFullWfull2 actual=%b required=0", wfull); end
        for (int i = 0; i < 3; i++) begin
            rinc = 1'b1;
            tick();
            checks++; if (rdata !== 8'(8'h77 + 8'h11 * i)) begin failures++; $display("[TB] FAIL simDrain%0d actual=%h required=%h", i, rdata, 8'(8'h77 + 8'h11 * i)); end
        end
        rinc = 1'b0;
        pulseClear();
    endtask

    task automatic test_fwft();
        fWdata = 8'hA5;
        fWinc = 1'b1;
        tick();
        fWinc = 1'b0;
        checks++; if (fRempty !== 1'b0) begin failures++; $display("[TB] FAIL fwftRempty actual=%b required=0", fRempty); end
        checks++; if (fRdata !== 8'hA5) begin failures++; $display("[TB] FAIL fwftData actual=%h required=a5", fRdata); end
        checks++; if (fCount !== 3'd1) begin failures++; $display("[TB] FAIL fwftCount actual=%0d required=1", fCount); end
        fRinc = 1'b1;
        tick();
        fRinc = 1'b0;
        checks++; if (fRempty !== 1'b1) begin failures++; $display("[TB] FAIL fwftPopRempty actual=%b required=1", fRempty); end
        checks++; if (fAempty !== 1'b1) begin failures++; $display("[TB] FAIL fwftPopAlmostEmpty actual=%b required=1", fAempty); end
        fWinc = 1'b1;
        fWdata = 8'h3C;
        tick();
        fWdata = 8'hC3;
        tick();
        fWinc = 1'b0;
        checks++; if (fRdata !== 8'h3C) begin failures++; $display("[TB] FAIL fwftHead actual=%h required=3c", fRdata); end
        fRinc = 1'b1;
        tick();
        checks++; if (fRdata !== 8'hC3) begin failures++; $display("[TB] FAIL fwftNext actual=%h required=c3", fRdata); end
        tick();
        fRinc = 1'b0;
        checks++; if (fRempty !== 1'b1) begin failures++; $display("[TB] FAIL fwftEnd actual=%b required=1", fRempty); end
    endtask

    task automatic test_wrap();
        winc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wdata = 8'(i);
            tick();
        end
        rinc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wdata = 8'(i + 2);
            tick();
            checks++; if (count !== 3'd2) begin failures++; $display("[TB] FAIL wrapCount%0d actual=%0d required=2", i, count); end
            checks++; if (rdata !== 8'(i)) begin failures++; $display("[TB] FAIL wrapData%0d actual=%h required=%h", i, rdata, 8'(i)); end
        end
        winc = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (rdata !== 8'(20 + i)) begin failures++; $display("[TB] FAIL wrapTail%0d actual=%h required=%h", i, rdata, 8'(20 + i)); end
        end
        rinc = 1'b0;
        checks++; if (rempty !== 1'b1) begin failures++; $display("[TB] FAIL wrapEmpty actual=%b required=1", rempty); end
    endtask

    task automatic test_async_reset();
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = 8'(8'h10 * (i + 1));
            tick();
        end
        winc = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("[TB] FAIL preResetCount actual=%0d required=3", count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL asyncCount actual=%0d required=0", count); end
        checks++; if (rempty !== 1'b1) begin failures++; $display("[TB] FAIL asyncRempty actual=%b required=1", rempty); end
        checks++; if (wfull !== 1'b0) begin failures++; $display("[TB] FAIL asyncWfull actual=%b required=0", wfull); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("[TB] FAIL asyncErrors actual=%b required=00", {overflow, underflow}); end
        #1;
        rst_n = 1'b1;
        tick();
        wdata = 8'h5A;
        winc = 1'b1;
        tick();
        winc = 1'b0;
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        checks++; if (rdata !== 8'h5A) begin failures++; $display("[TB] FAIL postResetData actual=%h required=5a", rdata); end
        checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL postResetCount actual=%0d required=0", count); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_simultaneous();
        test_fwft();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
